// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity constants and divisor helpers
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Clocks per oversample tick; never below one so the tick counter stays valid.
    function automatic int uart_div(input int clk_freq, input int baud, input int os);
        int d;
        d = clk_freq / (baud * os);
        if (d < 1) d = 1;
        return d;
    endfunction

    // Counter width for values 0..n-1, at least one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous receive buffer with full/empty flags
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop on an empty buffer is ignored; a push into a full buffer only lands when a pop frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero while empty so the outputs show their reset values.
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Read and write pointers with a wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable oversampling UART receiver with error flags and buffer
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV    = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int DIV_W  = cnt_width(DIV);
    localparam int OS_W   = cnt_width(OVERSAMPLE);
    localparam int BIT_W  = cnt_width(DATA_BITS);
    localparam int FIFO_W = DATA_BITS + 2;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  S_FIRST   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  S_MID     = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  S_LAST    = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0]  S_END     = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    rx_state_e            state_q;
    rx_state_e            state_d;
    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_prev;
    logic [1:0]           flush_cnt;
    logic                 falling;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic [OS_W-1:0]      samp_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 samp_a;
    logic                 samp_b;
    logic                 maj;
    logic                 vote_now;
    logic                 bit_end;
    logic [DATA_BITS-1:0] shreg;
    logic                 exp_par;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 push;
    logic [FIFO_W-1:0]    push_word;
    logic [FIFO_W-1:0]    head_word;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    // Two-flop synchroniser plus a delayed copy for edge detection; flush_cnt keeps reset values from faking an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            flush_cnt <= 2'd0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (flush_cnt != 2'd3) flush_cnt <= flush_cnt + 2'd1;
        end
    end

    assign falling = (flush_cnt == 2'd3) && rx_prev && !rx_s2;

    // Oversample tick divider, held at zero while idle so each frame starts phase-aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (state_q == IDLE || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick     = (state_q != IDLE) && (div_cnt == DIV_LAST);
    assign vote_now = tick && (samp_cnt == S_LAST);
    assign bit_end  = tick && (samp_cnt == S_END);
    assign maj      = (samp_a & samp_b) | (samp_a & rx_s2) | (samp_b & rx_s2);
    assign exp_par  = (PARITY_MODE == PARITY_ODD) ? ~(^shreg) : (^shreg);
    assign push_word = {shreg, perr_q, ferr_q | ~maj};

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; the last stop-bit vote writes the frame and returns to IDLE in the same cycle.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE:   if (falling) state_d = START;
            START: begin
                if (vote_now && maj)  state_d = IDLE;
                else if (bit_end)     state_d = DATA;
            end
            DATA: begin
                if (bit_end && bit_cnt == BIT_LAST)
                    state_d = (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: begin
                if (vote_now && stop_cnt == STOP_LAST) begin
                    state_d = IDLE;
                    push    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sample capture, bit counting, data shift and per-frame error accumulation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            samp_a   <= 1'b1;
            samp_b   <= 1'b1;
            shreg    <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else if (state_q == IDLE) begin
            samp_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else if (tick) begin
            samp_cnt <= (samp_cnt == S_END) ? '0 : samp_cnt + 1'b1;
            if (samp_cnt == S_FIRST) samp_a <= rx_s2;
            if (samp_cnt == S_MID)   samp_b <= rx_s2;
            if (samp_cnt == S_LAST) begin
                case (state_q)
                    DATA:    shreg  <= {maj, shreg[DATA_BITS-1:1]};
                    PARITY:  perr_q <= (maj != exp_par);
                    STOP:    if (!maj) ferr_q <= 1'b1;
                    default: ;
                endcase
            end
            if (samp_cnt == S_END) begin
                case (state_q)
                    DATA:    bit_cnt  <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                    STOP:    stop_cnt <= stop_cnt + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign pop = data_valid && data_ready;

    // Sticky overrun: set when a frame is dropped on a full buffer, cleared by the next pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          overrun <= 1'b0;
        else if (pop)                          overrun <= 1'b0;
        else if (push && fifo_full)            overrun <= 1'b1;
    end

    uart_rx_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (push_word),
        .pop     (pop),
        .rdata   (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign data_out   = head_word[FIFO_W-1:2];
    assign parity_err = head_word[1];
    assign frame_err  = head_word[0];
    assign data_valid = !fifo_empty;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed checks of uart_rx_cfg in 8N1 and 7E2 configurations
module tb_uart_rx_cfg;

    localparam int CLK_T   = 10;
    localparam int CLK_HZ  = 9600 * 16 * 4;
    localparam int BIT_T   = 64 * CLK_T;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_a, rx_b;
    logic       ready_a, ready_b;
    logic [7:0] dout_a;
    logic [6:0] dout_b;
    logic       perr_a, ferr_a, dv_a, ovr_a, busy_a;
    logic       perr_b, ferr_b, dv_b, ovr_b, busy_b;

    int   total = 0;
    int   bad   = 0;
    int   fall_cnt = 0;
    logic fall_dv = 1'b0;
    logic busy_last = 1'b0;
    int   f0;

    always #(CLK_T / 2) clk = ~clk;

    uart_rx_cfg #(
        .CLK_FREQ (CLK_HZ), .BAUD_RATE (9600), .OVERSAMPLE (16), .DATA_BITS (8),
        .PARITY_MODE (0), .STOP_BITS (1), .FIFO_DEPTH (4)
    ) dut_a (
        .clk (clk), .reset_n (reset_n), .rx (rx_a), .data_out (dout_a),
        .parity_err (perr_a), .frame_err (ferr_a), .data_valid (dv_a),
        .data_ready (ready_a), .overrun (ovr_a), .busy (busy_a)
    );

    uart_rx_cfg #(
        .CLK_FREQ (CLK_HZ), .BAUD_RATE (9600), .OVERSAMPLE (16), .DATA_BITS (7),
        .PARITY_MODE (2), .STOP_BITS (2), .FIFO_DEPTH (4)
    ) dut_b (
        .clk (clk), .reset_n (reset_n), .rx (rx_b), .data_out (dout_b),
        .parity_err (perr_b), .frame_err (ferr_b), .data_valid (dv_b),
        .data_ready (ready_b), .overrun (ovr_b), .busy (busy_b)
    );

    // Record data_valid at each busy falling edge of dut_a.
    always @(negedge clk) begin
        if (busy_last && !busy_a) begin
            fall_cnt = fall_cnt + 1;
            fall_dv  = dv_a;
        end
        busy_last = busy_a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_raw(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) rx_a = bits[i];
            else            rx_b = bits[i];
            #(BIT_T);
        end
    endtask

    task automatic send_8n1(input logic [7:0] d);
        send_raw(0, {7'h7f, 1'b1, d, 1'b0}, 10);
    endtask

    task automatic send_7e2(input logic [6:0] d, input logic p);
        send_raw(1, {5'h1f, 2'b11, p, d, 1'b0}, 11);
    endtask

    task automatic pop_a();
        @(negedge clk) ready_a = 1'b1;
        @(negedge clk) ready_a = 1'b0;
    endtask

    task automatic pop_b();
        @(negedge clk) ready_b = 1'b1;
        @(negedge clk) ready_b = 1'b0;
    endtask

    initial begin
        rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0; reset_n = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        chk("rst_dv",   dv_a,   0);
        chk("rst_dout", dout_a, 0);
        chk("rst_perr", perr_a, 0);
        chk("rst_ferr", ferr_a, 0);
        chk("rst_ovr",  ovr_a,  0);
        chk("rst_busy", busy_a, 0);

        // 8N1 frame 0xA5
        f0 = fall_cnt;
        send_8n1(8'hA5);
        repeat (4) @(negedge clk);
        chk("a5_falls", fall_cnt - f0, 1);
        chk("a5_lat",   fall_dv, 1);
        chk("a5_dv",    dv_a, 1);
        chk("a5_dout",  dout_a, 8'hA5);
        chk("a5_perr",  perr_a, 0);
        chk("a5_ferr",  ferr_a, 0);
        pop_a();
        chk("a5_empty", dv_a, 0);

        // 7E2: 0x35 has four ones, even parity bit should be 0; send 1
        send_7e2(7'h35, 1'b1);
        repeat (4) @(negedge clk);
        chk("e2_bad_dv",   dv_b, 1);
        chk("e2_bad_dout", dout_b, 7'h35);
        chk("e2_bad_perr", perr_b, 1);
        chk("e2_bad_ferr", ferr_b, 0);
        pop_b();
        // 0x07 has three ones, correct even parity bit is 1
        send_7e2(7'h07, 1'b1);
        repeat (4) @(negedge clk);
        chk("e2_ok_dout", dout_b, 7'h07);
        chk("e2_ok_perr", perr_b, 0);
        chk("e2_ok_ferr", ferr_b, 0);
        pop_b();
        chk("e2_empty", dv_b, 0);

        // 3-tick glitch on idle line
        f0 = fall_cnt;
        rx_a = 1'b0;
        #(12 * CLK_T);
        rx_a = 1'b1;
        repeat (10) @(negedge clk);
        chk("gl_busy_hi", busy_a, 1);
        repeat (60) @(negedge clk);
        chk("gl_busy_lo", busy_a, 0);
        chk("gl_dv",      dv_a, 0);
        chk("gl_falls",   fall_cnt - f0, 1);
        chk("gl_fall_dv", fall_dv, 0);

        // overrun: five frames with no consumer
        send_8n1(8'h11);
        send_8n1(8'h22);
        send_8n1(8'h33);
        send_8n1(8'h44);
        repeat (4) @(negedge clk);
        chk("ov_pre", ovr_a, 0);
        send_8n1(8'h55);
        repeat (4) @(negedge clk);
        chk("ov_set",   ovr_a, 1);
        chk("ov_head1", dout_a, 8'h11);
        pop_a();
        chk("ov_clr",   ovr_a, 0);
        chk("ov_head2", dout_a, 8'h22);
        pop_a();
        chk("ov_head3", dout_a, 8'h33);
        pop_a();
        chk("ov_head4", dout_a, 8'h44);
        pop_a();
        chk("ov_empty", dv_a, 0);

        // break: 12 bit-times low
        rx_a = 1'b0;
        #(12 * BIT_T);
        rx_a = 1'b1;
        #(BIT_T);
        chk("brk_dv",   dv_a, 1);
        chk("brk_dout", dout_a, 0);
        chk("brk_ferr", ferr_a, 1);
        chk("brk_perr", perr_a, 0);
        pop_a();
        chk("brk_one",  dv_a, 0);

        // reset during data bit 4, with one frame already buffered
        send_8n1(8'h81);
        repeat (4) @(negedge clk);
        chk("mr_pre_dv", dv_a, 1);
        rx_a = 1'b0;
        #(BIT_T);
        rx_a = 1'b1;
        #(4 * BIT_T);
        rx_a = 1'b0;
        #(BIT_T / 2);
        chk("mr_mid_busy", busy_a, 1);
        reset_n = 1'b0;
        #1;
        chk("mr_busy", busy_a, 0);
        chk("mr_dv",   dv_a, 0);
        chk("mr_dout", dout_a, 0);
        chk("mr_perr", perr_a, 0);
        chk("mr_ferr", ferr_a, 0);
        chk("mr_ovr",  ovr_a, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("mr_low_nostart", busy_a, 0);
        chk("mr_low_dv",      dv_a, 0);
        rx_a = 1'b1;
        #(2 * BIT_T);
        send_8n1(8'h3C);
        repeat (4) @(negedge clk);
        chk("mr_3c_dv",   dv_a, 1);
        chk("mr_3c_dout", dout_a, 8'h3C);
        chk("mr_3c_perr", perr_a, 0);
        chk("mr_3c_ferr", ferr_a, 0);
        pop_a();
        chk("mr_3c_one",  dv_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
